// File: rtl/mux4to1_rr_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 4:1 mux.
// Ownership is bounded to HOLD_MAX cycles while other requesters are waiting.
module mux4to1_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Req,
    output logic [1:0] Sel,
    output logic [3:0] Grant,
    output logic       Busy
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold;
    logic [3:0]       r_grant;
    logic [1:0]       r_sel;

    state_t           w_nxt_state;
    logic [1:0]       w_nxt_ptr;
    logic [CNT_W-1:0] w_nxt_hold;
    logic [3:0]       w_nxt_grant;
    logic [1:0]       w_nxt_sel;
    logic [3:0]       w_cand;
    logic [2:0]       w_pick;
    logic             w_own_req;

    // Returns {found, index} of the first asserted request scanning ptr, ptr+1, ... mod 4.
    function automatic logic [2:0] f_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // The current owner is masked out; in IDLE r_grant is zero so all requests compete.
    assign w_cand    = Req & ~r_grant;
    assign w_pick    = f_pick(w_cand, r_ptr);
    assign w_own_req = Req[r_sel];

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_hold  = r_hold;
        w_nxt_grant = r_grant;
        w_nxt_sel   = r_sel;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick[2]) begin
                    w_nxt_state = ST_GRANT;
                    w_nxt_ptr   = w_pick[1:0] + 2'd1;
                    w_nxt_hold  = CNT_W'(1);
                    w_nxt_grant = 4'b0001 << w_pick[1:0];
                    w_nxt_sel   = w_pick[1:0];
                end
            end
            ST_GRANT: begin
                if (w_own_req && (r_hold < CNT_W'(HOLD_MAX))) begin
                    w_nxt_hold = r_hold + CNT_W'(1);
                end else if (w_pick[2]) begin
                    // Voluntary release or hold expiry with someone waiting: hand off in the same edge.
                    w_nxt_ptr   = w_pick[1:0] + 2'd1;
                    w_nxt_hold  = CNT_W'(1);
                    w_nxt_grant = 4'b0001 << w_pick[1:0];
                    w_nxt_sel   = w_pick[1:0];
                end else if (!w_own_req) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_grant = 4'b0000;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_hold  <= '0;
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_hold  <= w_nxt_hold;
            r_grant <= w_nxt_grant;
            r_sel   <= w_nxt_sel;
        end
    end

    assign Grant = r_grant;
    assign Sel   = r_sel;
    assign Busy  = |r_grant;

endmodule
